// File: rtl/pool_window_gen_pkg.sv
// Shared definitions for the 2x2 pooling datapath: window size, default
// geometry, counter-width helper and the pixel-position classification.
package pool_window_gen_pkg;

    // Pooling window edge length (2x2 windows, stride 2)
    localparam int POOL_K    = 2;

    // Default datapath geometry
    localparam int DEF_WIDTH = 9;
    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

    // Width of a counter that must hold values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Role of the incoming pixel inside its 2x2 window
    typedef enum logic [1:0] {
        PK_TOP   = 2'd0,   // even row: goes to the line buffer
        PK_BOT_L = 2'd1,   // odd row, even col: bottom-left, parked in hold_q
        PK_BOT_R = 2'd2    // odd row, odd col: bottom-right, completes a window
    } pix_kind_e;

    // Classify a pixel from the LSBs of its row and column counters
    function automatic pix_kind_e pix_kind(input logic row_odd, input logic col_odd);
        pix_kind_e k;
        if (!row_odd)     k = PK_TOP;
        else if (!col_odd) k = PK_BOT_L;
        else              k = PK_BOT_R;
        return k;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer for the pooling window generator: IMG_W entries,
// one write port, two combinational read ports at addr and addr-1.
module pool_line_buf
    import pool_window_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_IMG_W,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic [WIDTH-1:0] o_rdata_m1
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               w_raddr_m1;

    // addr-1 only matters for odd addresses; clamp at 0 so index stays in range
    assign w_raddr_m1 = (i_raddr == '0) ? '0 : (i_raddr - AW'(1));

    assign o_rdata    = r_mem[i_raddr];
    assign o_rdata_m1 = r_mem[w_raddr_m1];

    // Storage is deliberately not reset: every entry is written on the even
    // row before the odd row of the same frame reads it.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

endmodule

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window generator: turns a raster pixel stream into
// non-overlapping windows (a00/a01 top row, a10/a11 bottom row) for the
// max-pool comparator tree. Even rows are parked in a line buffer; every
// odd-row odd-column pixel completes one window.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a00,
    output logic [WIDTH-1:0] a01,
    output logic [WIDTH-1:0] a10,
    output logic [WIDTH-1:0] a11,
    output logic             out_last,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    // Geometry must tile exactly into 2x2 windows
    if ((IMG_W % POOL_K) != 0 || IMG_W < POOL_K ||
        (IMG_H % POOL_K) != 0 || IMG_H < POOL_K) begin : g_bad_geometry
        $error("pool_window_gen: IMG_W and IMG_H must be even and >= 2");
    end

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [WIDTH-1:0] r_hold;

    logic             w_accept;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_load;
    logic             w_lb_we;
    pix_kind_e        w_kind;
    logic [WIDTH-1:0] w_lb_rd;
    logic [WIDTH-1:0] w_lb_rd_m1;

    // The output slot is free when empty or being drained this cycle; the
    // input stalls only while an unconsumed window is pending.
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_kind    = pix_kind(r_row[0], r_col[0]);
    assign w_lb_we   = w_accept && (w_kind == PK_TOP);
    assign w_load    = w_accept && (w_kind == PK_BOT_R);

    pool_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buf (
        .clk        (clk),
        .i_we       (w_lb_we),
        .i_waddr    (r_col),
        .i_wdata    (in_data),
        .i_raddr    (r_col),
        .o_rdata    (w_lb_rd),
        .o_rdata_m1 (w_lb_rd_m1)
    );

    // Raster position of the next pixel; wraps at end of row and of frame
    // so a new frame can follow without an idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : (r_row + RW'(1));
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Bottom-left pixel waits here for its right-hand neighbour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_accept && (w_kind == PK_BOT_L)) begin
            r_hold <= in_data;
        end
    end

    // Output slot: load a window on the completing pixel (even in the cycle
    // the previous one drains), otherwise clear valid once it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            a00       <= '0;
            a01       <= '0;
            a10       <= '0;
            a11       <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_last  <= w_row_end && w_col_end;
            a00       <= w_lb_rd_m1;
            a01       <= w_lb_rd;
            a10       <= r_hold;
            a11       <= in_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Single-cycle end-of-frame strobe following acceptance of the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_accept && w_col_end && w_row_end;
        end
    end

endmodule
